// File: rtl/axi_pkg.sv
// Shared AXI3 write-channel definitions: response codes, burst codes and the
// write-path state encoding used by both the write master and write slave.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_t;

    // The reserved burst encoding is sent as INCR.
    function automatic logic [1:0] legal_burst(input logic [1:0] burst);
        return (burst == 2'b11) ? BURST_INCR : burst;
    endfunction

endpackage

// File: rtl/axi_write_master.sv
// AXI3 write initiator: one command -> AW, cmd_len+1 W beats, B response.
// Optional B-wait timeout enabled by defining AXI_WRITE_MASTER_BTIMEOUT_EN.
module axi_write_master
    import axi_pkg::*;
#(
    parameter int          BUSWIDTH       = 32,
    parameter logic [3:0]  MASTER_ID      = 4'd0,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [31:0]         cmd_addr,
    input  logic [3:0]          cmd_len,
    input  logic [1:0]          cmd_burst,
    input  logic [BUSWIDTH-1:0] wdata_in,
    input  logic [3:0]          wstrb_in,
    input  logic                wdata_valid,
    output logic                wdata_ready,
    output logic                done,
    output logic [1:0]          done_resp,
    output logic [3:0]          AWID,
    output logic [31:0]         AWADDR,
    output logic [3:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic [1:0]          AWLOCK,
    output logic [3:0]          AWCACHE,
    output logic [2:0]          AWPROT,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [3:0]          WID,
    output logic [BUSWIDTH-1:0] WDATA,
    output logic [3:0]          WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [3:0]          BID,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY
);

    localparam logic [2:0] SIZE_CODE = 3'($clog2(BUSWIDTH / 8));

    wr_state_t   state_reg;
    logic        cmd_ready_reg;
    logic        awvalid_reg;
    logic [31:0] awaddr_reg;
    logic [3:0]  awlen_reg;
    logic [1:0]  awburst_reg;
    logic [3:0]  beat_cnt_reg;
    logic        bready_reg;
    logic        done_reg;
    logic [1:0]  done_resp_reg;
    logic        in_data;
    logic        w_fire;

`ifdef AXI_WRITE_MASTER_BTIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] to_cnt_reg;
`endif

    assign in_data     = (state_reg == ST_DATA);
    assign WVALID      = in_data & wdata_valid;
    assign w_fire      = WVALID & WREADY;
    assign wdata_ready = w_fire;
    assign WDATA       = in_data ? wdata_in : '0;
    assign WSTRB       = in_data ? wstrb_in : 4'd0;
    assign WLAST       = in_data && (beat_cnt_reg == 4'd0);
    assign WID         = MASTER_ID;

    assign AWID    = MASTER_ID;
    assign AWADDR  = awaddr_reg;
    assign AWLEN   = awlen_reg;
    assign AWSIZE  = SIZE_CODE;
    assign AWBURST = awburst_reg;
    assign AWLOCK  = 2'b00;
    assign AWCACHE = 4'b0000;
    assign AWPROT  = 3'b000;
    assign AWVALID = awvalid_reg;
    assign BREADY  = bready_reg;

    assign cmd_ready = cmd_ready_reg;
    assign done      = done_reg;
    assign done_resp = done_resp_reg;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_reg     <= ST_IDLE;
            cmd_ready_reg <= 1'b0;
            awvalid_reg   <= 1'b0;
            awaddr_reg    <= 32'd0;
            awlen_reg     <= 4'd0;
            awburst_reg   <= 2'b00;
            beat_cnt_reg  <= 4'd0;
            bready_reg    <= 1'b0;
            done_reg      <= 1'b0;
            done_resp_reg <= RESP_OKAY;
`ifdef AXI_WRITE_MASTER_BTIMEOUT_EN
            to_cnt_reg    <= '0;
`endif
        end else begin
            done_reg      <= 1'b0;
            done_resp_reg <= RESP_OKAY;
            case (state_reg)
                ST_IDLE: begin
                    cmd_ready_reg <= 1'b1;
                    // cmd_ready is registered, so the cycle after reset release never accepts.
                    if (cmd_valid && cmd_ready_reg) begin
                        awaddr_reg    <= cmd_addr;
                        awlen_reg     <= cmd_len;
                        awburst_reg   <= legal_burst(cmd_burst);
                        beat_cnt_reg  <= cmd_len;
                        cmd_ready_reg <= 1'b0;
                        awvalid_reg   <= 1'b1;
                        state_reg     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (AWREADY) begin
                        awvalid_reg <= 1'b0;
                        state_reg   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_fire) begin
                        if (beat_cnt_reg == 4'd0) begin
                            bready_reg <= 1'b1;
                            state_reg  <= ST_RESP;
`ifdef AXI_WRITE_MASTER_BTIMEOUT_EN
                            to_cnt_reg <= '0;
`endif
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg - 4'd1;
                        end
                    end
                end
                ST_RESP: begin
                    if (BVALID) begin
                        done_reg      <= 1'b1;
                        done_resp_reg <= (BID == MASTER_ID) ? BRESP : RESP_SLVERR;
                        bready_reg    <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
`ifdef AXI_WRITE_MASTER_BTIMEOUT_EN
                    else if (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                        done_reg      <= 1'b1;
                        done_resp_reg <= RESP_DECERR;
                        bready_reg    <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
`endif
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_master.sv
// Directed self-checking bench for axi_write_master; the bench itself plays
// the local device and a scripted AXI slave.
module tb_axi_write_master;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = 32'd0;
    logic [3:0]  cmd_len = 4'd0;
    logic [1:0]  cmd_burst = 2'b00;
    logic [31:0] wdata_in = 32'd0;
    logic [3:0]  wstrb_in = 4'hF;
    logic        wdata_valid = 1'b0;
    logic        wdata_ready;
    logic        done;
    logic [1:0]  done_resp;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic [1:0]  AWLOCK;
    logic [3:0]  AWCACHE;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic        AWREADY = 1'b0;
    logic [3:0]  WID;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY = 1'b0;
    logic [3:0]  BID = 4'd0;
    logic [1:0]  BRESP = 2'b00;
    logic        BVALID = 1'b0;
    logic        BREADY;

    int tests = 0;
    int fails = 0;

    axi_write_master #(
        .BUSWIDTH(32), .MASTER_ID(4'd0), .TIMEOUT_CYCLES(8)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_burst(cmd_burst),
        .wdata_in(wdata_in), .wstrb_in(wstrb_in), .wdata_valid(wdata_valid),
        .wdata_ready(wdata_ready), .done(done), .done_resp(done_resp),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    // Accept a command and complete AW after aw_wait stalled cycles.
    task automatic issue(input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input logic [1:0] exp_burst,
                         input int aw_wait);
        #1 chk("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_addr = addr; cmd_len = len; cmd_burst = burst;
        step();
        cmd_valid = 1'b0; cmd_addr = 32'hDEAD_BEEF; cmd_len = 4'hF;
        wdata_valid = 1'b1; wdata_in = 32'h5555_5555;
        #1;
        chk("awvalid", AWVALID, 1'b1);
        chk("awaddr", AWADDR, addr);
        chk("awlen", AWLEN, len);
        chk("awsize", AWSIZE, 3'd2);
        chk("awburst", AWBURST, exp_burst);
        chk("awid", AWID, 4'd0);
        chk("wvalid_in_addr", WVALID, 1'b0);
        chk("cmd_ready_busy", cmd_ready, 1'b0);
        for (int i = 0; i < aw_wait; i++) begin
            step();
            #1;
            chk("awvalid_hold", AWVALID, 1'b1);
            chk("awaddr_hold", AWADDR, addr);
            chk("wvalid_hold", WVALID, 1'b0);
        end
        AWREADY = 1'b1;
        step();
        AWREADY = 1'b0;
        wdata_valid = 1'b0;
        #1 chk("awvalid_drop", AWVALID, 1'b0);
    endtask

    // Stream n beats base+i; with toggle, WREADY alternates starting low.
    task automatic do_beats(input int n, input logic [31:0] base, input bit toggle);
        int idx = 0;
        int cyc = 0;
        bit wr = 1'b0;
        while (idx < n && cyc < 40) begin
            WREADY = toggle ? wr : 1'b1;
            wdata_valid = 1'b1;
            wdata_in = base + 32'(idx);
            #1;
            chk("wvalid", WVALID, 1'b1);
            chk("wdata", WDATA, base + 32'(idx));
            chk("wlast", WLAST, (idx == n - 1));
            chk("wdata_ready", wdata_ready, WREADY);
            if (WREADY) idx++;
            wr = ~wr;
            step();
            cyc++;
        end
        WREADY = 1'b0;
        wdata_valid = 1'b0;
        chk("beat_count", 64'(idx), 64'(n));
        #1;
        chk("bready_resp", BREADY, 1'b1);
        chk("wvalid_resp", WVALID, 1'b0);
    endtask

    task automatic do_resp(input logic [3:0] bid, input logic [1:0] bresp, input logic [1:0] exp);
        BVALID = 1'b1; BID = bid; BRESP = bresp;
        step();
        BVALID = 1'b0; BID = 4'd0; BRESP = 2'b00;
        #1;
        chk("done_pulse", done, 1'b1);
        chk("done_resp", done_resp, exp);
        chk("cmd_ready_at_done", cmd_ready, 1'b1);
        chk("bready_drop", BREADY, 1'b0);
        step();
        chk("done_clear", done, 1'b0);
        $display("[TB] txn done bid=%0h bresp=%0h done_resp=%0h", bid, bresp, exp);
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_awvalid", AWVALID, 1'b0);
        chk("rst_wvalid", WVALID, 1'b0);
        chk("rst_wlast", WLAST, 1'b0);
        chk("rst_bready", BREADY, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_awaddr", AWADDR, 32'd0);
        chk("rst_wdata", WDATA, 32'd0);
        ARESET = 1'b0;
        #1 chk("rel_cmd_ready", cmd_ready, 1'b0);
        step();

        // Single beat, zero-wait slave
        issue(32'h100, 4'd0, 2'b01, 2'b01, 0);
        do_beats(1, 32'h1234_5678, 1'b0);
        do_resp(4'd0, 2'b00, 2'b00);

        // Four beats with W backpressure
        issue(32'h200, 4'd3, 2'b01, 2'b01, 0);
        do_beats(4, 32'hA0, 1'b1);
        do_resp(4'd0, 2'b00, 2'b00);

        // AW backpressure of 5 cycles, WRAP burst
        issue(32'h300, 4'd1, 2'b10, 2'b10, 5);
        do_beats(2, 32'hB0, 1'b0);
        do_resp(4'd0, 2'b00, 2'b00);

        // Error responses; reserved burst code goes out as INCR
        issue(32'h400, 4'd0, 2'b11, 2'b01, 0);
        do_beats(1, 32'hC0, 1'b0);
        do_resp(4'd0, 2'b10, 2'b10);
        issue(32'h404, 4'd0, 2'b00, 2'b00, 0);
        do_beats(1, 32'hC1, 1'b0);
        do_resp(4'd5, 2'b00, 2'b10);

        // B never arrives
        issue(32'h500, 4'd0, 2'b01, 2'b01, 0);
        do_beats(1, 32'hD0, 1'b0);
`ifdef AXI_WRITE_MASTER_BTIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            chk("to_no_done", done, 1'b0);
            chk("to_bready", BREADY, 1'b1);
            step();
        end
        chk("to_done", done, 1'b1);
        chk("to_resp", done_resp, 2'b11);
        chk("to_bready_drop", BREADY, 1'b0);
        chk("to_cmd_ready", cmd_ready, 1'b1);
        step();
        $display("[TB] txn timeout done_resp=3");
`else
        for (int k = 0; k < 100; k++) begin
            if (done) chk("no_timeout_done", done, 1'b0);
            step();
        end
        chk("no_timeout_bready", BREADY, 1'b1);
        chk("no_timeout_idle", cmd_ready, 1'b0);
        do_resp(4'd0, 2'b00, 2'b00);
`endif

        // Reset after beat 2 of 4, then a clean burst
        issue(32'h600, 4'd3, 2'b01, 2'b01, 0);
        WREADY = 1'b1; wdata_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wdata_in = 32'hE0 + 32'(i);
            step();
        end
        ARESET = 1'b1;
        step();
        #1;
        chk("mid_rst_awvalid", AWVALID, 1'b0);
        chk("mid_rst_wvalid", WVALID, 1'b0);
        chk("mid_rst_wlast", WLAST, 1'b0);
        chk("mid_rst_bready", BREADY, 1'b0);
        chk("mid_rst_cmd_ready", cmd_ready, 1'b0);
        chk("mid_rst_wready_out", wdata_ready, 1'b0);
        WREADY = 1'b0; wdata_valid = 1'b0;
        ARESET = 1'b0;
        step();
        $display("[TB] txn aborted by reset");
        issue(32'h700, 4'd3, 2'b01, 2'b01, 0);
        do_beats(4, 32'hF0, 1'b0);
        do_resp(4'd0, 2'b01, 2'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
